// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 scan-code decoder.
package ps2_pkg;

  // Frame receiver states, one per field of the 11-bit PS/2 frame
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned BYTE_W = 8;

  // Prefix bytes
  localparam logic [BYTE_W-1:0] CODE_EXT    = 8'hE0;
  localparam logic [BYTE_W-1:0] CODE_BRK    = 8'hF0;

  // Keyboard replies: reported, never treated as key codes
  localparam logic [BYTE_W-1:0] CODE_BAT    = 8'hAA;
  localparam logic [BYTE_W-1:0] CODE_ACK    = 8'hFA;
  localparam logic [BYTE_W-1:0] CODE_RESEND = 8'hFE;
  localparam logic [BYTE_W-1:0] CODE_ECHO   = 8'hEE;

  // Currently held key
  typedef struct packed {
    logic [BYTE_W-1:0] code;
    logic              valid;
    logic              ext;
  } ps2_key_t;

  // True for keyboard reply bytes that must leave key state alone
  function automatic logic is_reply(input logic [BYTE_W-1:0] b);
    return (b == CODE_BAT) || (b == CODE_ACK) ||
           (b == CODE_RESEND) || (b == CODE_ECHO);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one PS/2 line.
// The filtered output idles high and only follows the synchronized input
// after FILTER_LEN consecutive samples that disagree with it.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_line
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             r_meta;
  logic             r_sync;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous line into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
    end
  end

  // Count consecutive disagreeing samples; flip once the run is long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else if (r_sync != r_filt) begin
      if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
        r_filt <= r_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_line = r_filt;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: filters the raw lines, deframes 11-bit frames on
// falling clock edges, and tracks the currently held key from make / break
// (F0) / extended (E0) scan-code sequences.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_dat,
  output logic [BYTE_W-1:0] key_out,
  output logic              key_valid,
  output logic              key_ext,
  output logic [BYTE_W-1:0] code_byte,
  output logic              code_strobe,
  output logic              frame_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BIT_W = 3;

  logic w_clk_f;
  logic w_dat_f;
  logic r_clk_f_d;
  logic w_fall;

  ps2_state_e r_state;
  ps2_state_e w_state_nxt;

  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic [BIT_W-1:0]  r_bitcnt;
  logic [BIT_W-1:0]  w_bitcnt_nxt;
  logic              r_parity;
  logic              w_parity_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [TMR_W-1:0]  w_timer_nxt;

  logic              r_ext_pend;
  logic              w_ext_pend_nxt;
  logic              r_brk_pend;
  logic              w_brk_pend_nxt;
  ps2_key_t          r_key;
  ps2_key_t          w_key_nxt;
  logic [BYTE_W-1:0] r_code_byte;
  logic [BYTE_W-1:0] w_code_byte_nxt;
  logic              r_code_strobe;
  logic              w_code_strobe_nxt;
  logic              r_frame_err;
  logic              w_frame_err_nxt;

  logic              w_frame_done;
  logic              w_frame_ok;
  logic              w_timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (ps2_clk),
    .o_line (w_clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (ps2_dat),
    .o_line (w_dat_f)
  );

  // Delayed filtered clock for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_f_d <= 1'b1;
    end else begin
      r_clk_f_d <= w_clk_f;
    end
  end

  assign w_fall = r_clk_f_d & ~w_clk_f;

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, deframing, timeout and key-tracking decisions
  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_bitcnt_nxt      = r_bitcnt;
    w_parity_nxt      = r_parity;
    w_timer_nxt       = r_timer;
    w_ext_pend_nxt    = r_ext_pend;
    w_brk_pend_nxt    = r_brk_pend;
    w_key_nxt         = r_key;
    w_code_byte_nxt   = r_code_byte;
    w_code_strobe_nxt = 1'b0;
    w_frame_err_nxt   = 1'b0;
    w_frame_done      = 1'b0;
    w_frame_ok        = 1'b0;
    w_timeout         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (w_fall && !w_dat_f) begin
          w_state_nxt  = ST_DATA;
          w_bitcnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_fall) begin
          w_shift_nxt  = {w_dat_f, r_shift[BYTE_W-1:1]};
          w_bitcnt_nxt = r_bitcnt + BIT_W'(1);
          if (r_bitcnt == BIT_W'(BYTE_W - 1)) begin
            w_state_nxt = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (w_fall) begin
          w_parity_nxt = w_dat_f;
          w_state_nxt  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_fall) begin
          w_state_nxt  = ST_IDLE;
          w_frame_done = 1'b1;
          w_frame_ok   = (^{r_shift, r_parity}) & w_dat_f;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abandon a stalled partial frame; a fresh edge always wins
    if (r_state != ST_IDLE) begin
      if (w_fall) begin
        w_timer_nxt = '0;
      end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
        w_timeout   = 1'b1;
      end else begin
        w_timer_nxt = r_timer + TMR_W'(1);
      end
    end

    if (w_frame_done && w_frame_ok) begin
      w_code_strobe_nxt = 1'b1;
      w_code_byte_nxt   = r_shift;
      if (r_shift == CODE_EXT) begin
        w_ext_pend_nxt = 1'b1;
      end else if (r_shift == CODE_BRK) begin
        w_brk_pend_nxt = 1'b1;
      end else begin
        w_ext_pend_nxt = 1'b0;
        w_brk_pend_nxt = 1'b0;
        if (!is_reply(r_shift)) begin
          if (r_brk_pend) begin
            // Release only the key that is actually held
            if ((r_shift == r_key.code) && (r_ext_pend == r_key.ext)) begin
              w_key_nxt = '0;
            end
          end else begin
            w_key_nxt = '{code: r_shift, valid: 1'b1, ext: r_ext_pend};
          end
        end
      end
    end else if ((w_frame_done && !w_frame_ok) || w_timeout) begin
      w_frame_err_nxt = 1'b1;
      w_ext_pend_nxt  = 1'b0;
      w_brk_pend_nxt  = 1'b0;
    end
  end

  // Datapath, pending flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_parity      <= 1'b0;
      r_timer       <= '0;
      r_ext_pend    <= 1'b0;
      r_brk_pend    <= 1'b0;
      r_key         <= '0;
      r_code_byte   <= '0;
      r_code_strobe <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_shift       <= w_shift_nxt;
      r_bitcnt      <= w_bitcnt_nxt;
      r_parity      <= w_parity_nxt;
      r_timer       <= w_timer_nxt;
      r_ext_pend    <= w_ext_pend_nxt;
      r_brk_pend    <= w_brk_pend_nxt;
      r_key         <= w_key_nxt;
      r_code_byte   <= w_code_byte_nxt;
      r_code_strobe <= w_code_strobe_nxt;
      r_frame_err   <= w_frame_err_nxt;
    end
  end

  assign key_out     = r_key.code;
  assign key_valid   = r_key.valid;
  assign key_ext     = r_key.ext;
  assign code_byte   = r_code_byte;
  assign code_strobe = r_code_strobe;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: a table of directed frames,
// hand-written corner sequences (glitches, timeout, reset mid-frame) and
// random frames checked against a scan-code level reference model.
`timescale 1ns/1ps
module tb_ps2_scan_decoder;

  localparam int unsigned FILT = 4;
  localparam int unsigned TMO  = 1000;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] key_out;
  logic       key_valid;
  logic       key_ext;
  logic [7:0] code_byte;
  logic       code_strobe;
  logic       frame_err;

  ps2_scan_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .key_ext     (key_ext),
    .code_byte   (code_byte),
    .code_strobe (code_strobe),
    .frame_err   (frame_err)
  );

  always #10 clk = ~clk;

  int         n_cmp  = 0;
  int         n_bad  = 0;
  int         n_strobe = 0;
  int         n_err    = 0;
  logic [7:0] strobe_code = 8'h00;
  int         half = 20;

  // Pulse counters; code_byte is captured in the same cycle as the strobe
  always @(negedge clk) begin
    if (code_strobe) begin
      n_strobe    = n_strobe + 1;
      strobe_code = code_byte;
    end
    if (frame_err) n_err = n_err + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of a frame; optional extra stall after bit stall_idx
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits, input int stall_idx, input int stall_cyc);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (~(^b)) ^ bad_par;
    f[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat = f[i];
      wait_cyc(half);
      ps2_clk = 1'b0;
      wait_cyc(half);
      ps2_clk = 1'b1;
      if (i == stall_idx) wait_cyc(stall_cyc);
    end
    @(negedge clk);
    ps2_dat = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] e_code, input logic [7:0] e_key,
                               input logic e_valid, input logic e_ext);
    check($sformatf("%s code_byte", tag), int'(code_byte), int'(e_code));
    check($sformatf("%s key_out", tag),   int'(key_out),   int'(e_key));
    check($sformatf("%s key_valid", tag), int'(key_valid), int'(e_valid));
    check($sformatf("%s key_ext", tag),   int'(key_ext),   int'(e_ext));
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int stall_cyc, input int e_strobe,
                             input int e_err, input logic [7:0] e_code, input logic [7:0] e_key,
                             input logic e_valid, input logic e_ext);
    int s0;
    int r0;
    s0 = n_strobe;
    r0 = n_err;
    send_bits(b, bad_par, bad_stop, 11, (stall_cyc > 0) ? 4 : -1, stall_cyc);
    wait_cyc(int'(FILT) + 12);
    check($sformatf("%s strobes", tag), n_strobe - s0, e_strobe);
    check($sformatf("%s frame_errs", tag), n_err - r0, e_err);
    if (e_strobe == 1) check($sformatf("%s code@strobe", tag), int'(strobe_code), int'(b));
    check_outputs(tag, e_code, e_key, e_valid, e_ext);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    int         e_strobe;
    int         e_err;
    logic [7:0] e_code;
    logic [7:0] e_key;
    logic       e_valid;
    logic       e_ext;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  logic [7:0] specials [4];
  logic [7:0] makes    [4];

  // Reference model state (scan-code level)
  logic [7:0] m_key;
  logic       m_valid;
  logic       m_ext;
  logic       m_extp;
  logic       m_brkp;
  logic [7:0] m_code;

  initial begin
    int s0;
    int r0;

    specials = '{8'hAA, 8'hFA, 8'hFE, 8'hEE};
    makes    = '{8'h1C, 8'h1B, 8'h23, 8'h75};

    vecs[0]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 8'h1C, 1'b1, 1'b0};
    vecs[1]  = '{8'hF0, 0, 0, 1, 0, 8'hF0, 8'h1C, 1'b1, 1'b0};
    vecs[2]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 8'h1C, 1'b1, 1'b0};
    vecs[4]  = '{8'hF0, 0, 0, 1, 0, 8'hF0, 8'h1C, 1'b1, 1'b0};
    vecs[5]  = '{8'h23, 0, 0, 1, 0, 8'h23, 8'h1C, 1'b1, 1'b0};
    vecs[6]  = '{8'hE0, 0, 0, 1, 0, 8'hE0, 8'h1C, 1'b1, 1'b0};
    vecs[7]  = '{8'h75, 0, 0, 1, 0, 8'h75, 8'h75, 1'b1, 1'b1};
    vecs[8]  = '{8'hE0, 0, 0, 1, 0, 8'hE0, 8'h75, 1'b1, 1'b1};
    vecs[9]  = '{8'hF0, 0, 0, 1, 0, 8'hF0, 8'h75, 1'b1, 1'b1};
    vecs[10] = '{8'h75, 0, 0, 1, 0, 8'h75, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 8'h1C, 1'b1, 1'b0};
    vecs[12] = '{8'h1D, 1, 0, 0, 1, 8'h1C, 8'h1C, 1'b1, 1'b0};
    vecs[13] = '{8'h1D, 0, 1, 0, 1, 8'h1C, 8'h1C, 1'b1, 1'b0};
    vecs[14] = '{8'hAA, 0, 0, 1, 0, 8'hAA, 8'h1C, 1'b1, 1'b0};
    vecs[15] = '{8'h1C, 0, 0, 1, 0, 8'h1C, 8'h1C, 1'b1, 1'b0};
    vecs[16] = '{8'hE0, 0, 0, 1, 0, 8'hE0, 8'h1C, 1'b1, 1'b0};
    vecs[17] = '{8'h1D, 1, 0, 0, 1, 8'hE0, 8'h1C, 1'b1, 1'b0};
    vecs[18] = '{8'h75, 0, 0, 1, 0, 8'h75, 8'h75, 1'b1, 1'b0};
    vecs[19] = '{8'hF0, 0, 0, 1, 0, 8'hF0, 8'h75, 1'b1, 1'b0};
    vecs[20] = '{8'h75, 0, 0, 1, 0, 8'h75, 8'h00, 1'b0, 1'b0};
    vecs[21] = '{8'hE0, 0, 0, 1, 0, 8'hE0, 8'h00, 1'b0, 1'b0};
    vecs[22] = '{8'h75, 0, 0, 1, 0, 8'h75, 8'h75, 1'b1, 1'b1};
    vecs[23] = '{8'hF0, 0, 0, 1, 0, 8'hF0, 8'h75, 1'b1, 1'b1};
    vecs[24] = '{8'h75, 0, 0, 1, 0, 8'h75, 8'h75, 1'b1, 1'b1};

    // Reset state
    wait_cyc(5);
    check("reset code_strobe", int'(code_strobe), 0);
    check("reset frame_err", int'(frame_err), 0);
    check_outputs("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    wait_cyc(10);

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      frame_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop, 0,
                  vecs[i].e_strobe, vecs[i].e_err, vecs[i].e_code, vecs[i].e_key,
                  vecs[i].e_valid, vecs[i].e_ext);
    end

    // Short clock glitches while data is low must not start a frame
    s0 = n_strobe;
    r0 = n_err;
    @(negedge clk);
    ps2_dat = 1'b0;
    wait_cyc(int'(FILT) + 6);
    for (int g = 1; g < int'(FILT); g++) begin
      ps2_clk = 1'b0;
      wait_cyc(g);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_dat = 1'b1;
    wait_cyc(int'(FILT) + 10);
    check("glitch strobes", n_strobe - s0, 0);
    check("glitch frame_errs", n_err - r0, 0);
    frame_check("post_glitch", 8'h1C, 0, 0, 0, 1, 0, 8'h1C, 8'h1C, 1'b1, 1'b0);

    // Stalled partial frame is abandoned and clears the pending prefix
    frame_check("tmo_prefix", 8'hE0, 0, 0, 0, 1, 0, 8'hE0, 8'h1C, 1'b1, 1'b0);
    s0 = n_strobe;
    r0 = n_err;
    send_bits(8'h1B, 0, 0, 5, -1, 0);
    wait_cyc(int'(TMO) + 100);
    check("timeout frame_errs", n_err - r0, 1);
    check("timeout strobes", n_strobe - s0, 0);
    check_outputs("timeout", 8'hE0, 8'h1C, 1'b1, 1'b0);
    frame_check("post_timeout", 8'h1B, 0, 0, 0, 1, 0, 8'h1B, 8'h1B, 1'b1, 1'b0);

    // A gap just under the timeout keeps the frame alive
    frame_check("near_timeout", 8'h23, 0, 0, int'(TMO) - 2 * half - 40,
                1, 0, 8'h23, 8'h23, 1'b1, 1'b0);

    // Reset in the middle of a frame clears outputs at once
    send_bits(8'h5A, 0, 0, 4, -1, 0);
    #3 rst_n = 1'b0;
    #1;
    check("midrst code_strobe", int'(code_strobe), 0);
    check("midrst frame_err", int'(frame_err), 0);
    check_outputs("midrst", 8'h00, 8'h00, 1'b0, 1'b0);
    wait_cyc(5);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(10);
    frame_check("post_rst", 8'h1C, 0, 0, 0, 1, 0, 8'h1C, 8'h1C, 1'b1, 1'b0);

    // Random frames against the scan-code model
    m_key = 8'h1C; m_valid = 1'b1; m_ext = 1'b0;
    m_extp = 1'b0; m_brkp = 1'b0; m_code = 8'h1C;
    for (int i = 0; i < 80; i++) begin
      logic [7:0] b;
      bit         bp;
      bit         bs;
      int         r;
      int         es;
      int         ee;
      r = int'($urandom_range(0, 11));
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = m_key;
        5:       b = specials[$urandom_range(0, 3)];
        6, 7, 8: b = makes[$urandom_range(0, 3)];
        default: b = 8'($urandom);
      endcase
      r  = int'($urandom_range(0, 9));
      bp = (r == 0);
      bs = (r == 1);
      half = int'($urandom_range(12, 25));

      if (bp || bs) begin
        es = 0; ee = 1;
        m_extp = 1'b0; m_brkp = 1'b0;
      end else begin
        es = 1; ee = 0;
        m_code = b;
        if (b == 8'hE0) begin
          m_extp = 1'b1;
        end else if (b == 8'hF0) begin
          m_brkp = 1'b1;
        end else begin
          if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE})) begin
            if (m_brkp) begin
              if (b == m_key && m_extp == m_ext) begin
                m_key = 8'h00; m_valid = 1'b0; m_ext = 1'b0;
              end
            end else begin
              m_key = b; m_valid = 1'b1; m_ext = m_extp;
            end
          end
          m_extp = 1'b0; m_brkp = 1'b0;
        end
      end
      frame_check($sformatf("rnd%0d_%02h", i, b), b, bp, bs, 0, es, ee,
                  m_code, m_key, m_valid, m_ext);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive identical synchronized samples needed to change a filtered PS/2 line.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 100000: idle clk cycles (2 ms at 50 MHz) after which a partial frame is abandoned.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, 50 MHz; the only clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous.
REQ-006 The block SHALL have port ps2_dat, input, 1 bit: raw PS/2 data from the keyboard, asynchronous.
REQ-007 The block SHALL have port key_out, output, 8 bits: make code of the key currently held, or 0x00 when no key is held.
REQ-008 The block SHALL have port key_valid, output, 1 bit: high while key_out holds a pressed key.
REQ-009 The block SHALL have port key_ext, output, 1 bit: high when the held key was preceded by the 0xE0 prefix.
REQ-010 The block SHALL have port code_byte, output, 8 bits: last byte received without error.
REQ-011 The block SHALL have port code_strobe, output, 1 bit: one-cycle pulse for each byte received without error.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse for each rejected frame.

Function
REQ-013 Both PS/2 lines SHALL pass through a 2-flop synchronizer and then a stability filter; a filtered line SHALL change only after FILTER_LEN consecutive equal samples.
REQ-014 Data SHALL be sampled from filtered ps2_dat on the cycle a falling edge of filtered ps2_clk is detected.
REQ-015 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP.
- IDLE->DATA on an edge with dat=0; an edge with dat=1 SHALL leave it in IDLE.
- DATA SHALL shift 8 bits, LSB first, then go to PARITY.
- PARITY SHALL capture the parity bit, then go to STOP.
- STOP SHALL return to IDLE on the next edge.
REQ-016 A frame SHALL be accepted only if the 8 data bits plus parity have odd parity and the stop bit is 1; otherwise frame_err SHALL pulse and no byte is reported.
REQ-017 For an accepted frame, code_strobe SHALL pulse exactly once, one clk after the stop-bit edge; code_byte, key_out, key_valid and key_ext SHALL update on that same cycle.
REQ-018 If the FSM is outside IDLE and no edge arrives for TIMEOUT_CYC cycles, it SHALL return to IDLE and pulse frame_err. An edge in the same cycle as the timeout SHALL take priority and restart the count.
REQ-019 Byte 0xE0 SHALL set ext_pending; byte 0xF0 SHALL set brk_pending. Neither byte SHALL change key state.
REQ-020 A non-prefix byte with brk_pending set SHALL clear key_out, key_valid and key_ext only if it equals key_out and ext_pending equals key_ext; otherwise key state SHALL be unchanged.
REQ-021 A non-prefix byte with brk_pending clear SHALL load key_out with the byte, key_ext with ext_pending, and set key_valid=1. A repeated identical make SHALL still pulse code_strobe.
REQ-022 Bytes 0xAA, 0xFA, 0xFE and 0xEE SHALL be reported on code_byte but SHALL NOT alter key state.
REQ-023 Both pending flags SHALL clear after any non-prefix byte and after any frame_err.

Reset
REQ-024 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, counters and pending flags SHALL be 0, and filtered lines SHALL be 1.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, decoding SHALL begin at the next start bit.

Structure
REQ-026 Package ps2_pkg SHALL hold the FSM state encoding and the constants 0xE0, 0xF0, 0xAA, 0xFA, 0xFE, 0xEE.
REQ-027 The synchronizer and stability filter SHALL be sub-module ps2_line_filter, instantiated once for ps2_clk and once for ps2_dat.
REQ-028 The FSM and the decode logic SHALL reside in ps2_scan_decoder.

Verification
REQ-029 Frame 0x1C (parity 0, stop 1) at a 12.5 kHz PS/2 clock -> one code_strobe, code_byte=0x1C, key_out=0x1C, key_valid=1, key_ext=0.
REQ-030 Bytes F0,1C after a 0x1C make -> key_out=0x00, key_valid=0. Bytes F0,23 instead -> key_out stays 0x1C.
REQ-031 Bytes E0,75 -> key_out=0x75, key_ext=1. Then E0,F0,75 -> key_valid=0.
REQ-032 Frame 0x1D with bad parity -> frame_err pulses once, no code_strobe, key state unchanged. Frame with stop=0 -> same response.
REQ-033 Stop the PS/2 clock after 4 data bits for 2.1 ms, then send a full frame 0x1B -> one frame_err pulse, then key_out=0x1B.
REQ-034 1-cycle glitches on ps2_clk shorter than FILTER_LEN -> no state change. Assert rst_n=0 mid-frame -> all outputs 0 immediately.
